dr_link_rx_fifo: RTL and testbench

- Clocked receiver for a W-bit dual-rail, return-to-zero (four-phase) asynchronous link. Bridges the self-timed pipeline into the synchronous domain.
- Synchronises every rail and detects codeword completion and spacers. Drives the four-phase acknowledge and buffers decoded words in a DEPTH-entry first-word-fall-through FIFO with a valid/ready output.
- Successor to the single dual-rail memory cell. Adds width, depth, a reset init value, illegal-code detection and backpressure.

---
 rtl/dr_link_pkg.sv | 66 ++++++
 rtl/dr_rx_fifo.sv | 71 +++++++
 rtl/dr_link_rx_fifo.sv | 128 ++++++++++++
 tb/tb_dr_link_rx_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dr_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dr_link_pkg
//  Purpose  : Dual-rail code points, receiver FSM states and codeword helpers.
//  Revision : 1.0
// ============================================================================
package dr_link_pkg;

    localparam logic [1:0] DR_SPACER  = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    // Helpers take a zero-padded vector plus the live pair count.
    localparam int DR_MAX_W = 64;

    typedef logic [2*DR_MAX_W-1:0] dr_rails_t;
    typedef logic [DR_MAX_W-1:0]   dr_word_t;

    typedef enum logic [0:0] {
        WAIT_DATA   = 1'b0,
        WAIT_SPACER = 1'b1
    } dr_state_e;

    function automatic logic dr_complete(input dr_rails_t rails, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DR_MAX_W; i++) begin
            if (i < width && (rails[2*i +: 2] == DR_SPACER || rails[2*i +: 2] == DR_ILLEGAL))
                ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic dr_spacer(input dr_rails_t rails, input int width);
        logic sp;
        sp = 1'b1;
        for (int i = 0; i < DR_MAX_W; i++) begin
            if (i < width && rails[2*i +: 2] != DR_SPACER)
                sp = 1'b0;
        end
        return sp;
    endfunction

    function automatic logic dr_illegal(input dr_rails_t rails, input int width);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DR_MAX_W; i++) begin
            if (i < width && rails[2*i +: 2] == DR_ILLEGAL)
                bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic dr_word_t dr_decode(input dr_rails_t rails, input int width);
        dr_word_t w;
        w = '0;
        for (int i = 0; i < DR_MAX_W; i++) begin
            if (i < width)
                w[i] = rails[2*i+1];
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dr_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dr_rx_fifo
//  Purpose  : First-word-fall-through FIFO; dout shows INIT while empty.
//  Revision : 1.0
// ============================================================================
module dr_rx_fifo
    import dr_link_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             do_push, do_pop;

    // A push into a full buffer is only legal when the head leaves this cycle.
    assign do_pop  = pop && (cnt_q != '0);
    assign do_push = push && ((cnt_q != C_FULL) || do_pop);

    always_comb begin
        wptr_d = wptr_q + PTR_W'(do_push);
        rptr_d = rptr_q + PTR_W'(do_pop);
        cnt_d  = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wptr_q] <= push_data;
    end

    assign dout_vld = (cnt_q != '0);
    assign dout     = dout_vld ? mem_q[rptr_q] : INIT;
    assign count    = cnt_q;

endmodule
`default_nettype wire

// File: rtl/dr_link_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dr_link_rx_fifo
//  Purpose  : Four-phase dual-rail link receiver feeding a valid/ready FIFO.
//  Revision : 1.0
// ============================================================================
module dr_link_rx_fifo
    import dr_link_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2*WIDTH-1:0]         in,
    output logic                       ack_o,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    input  logic                       dout_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_o,
    input  logic                       err_clr
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [2*WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [2*WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [2*WIDTH-1:0] prev_q, prev_d;
    dr_state_e          state_q, state_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;

    logic [2*WIDTH-1:0] w_rails;
    dr_rails_t          w_rails_ext;
    dr_word_t           w_decoded;
    logic               w_complete, w_spacer, w_illegal, w_stable;
    logic               w_pop, w_push, w_push_ok;

    assign w_rails = sync_q[SYNC_STAGES-1];

    always_comb begin
        w_rails_ext                = '0;
        w_rails_ext[2*WIDTH-1:0]   = w_rails;
    end

    assign w_complete = dr_complete(w_rails_ext, WIDTH);
    assign w_spacer   = dr_spacer(w_rails_ext, WIDTH);
    assign w_illegal  = dr_illegal(w_rails_ext, WIDTH);
    assign w_decoded  = dr_decode(w_rails_ext, WIDTH);
    // One extra cycle of agreement absorbs skew between individual rail synchronisers.
    assign w_stable   = (w_rails == prev_q);

    assign w_pop     = dout_vld && dout_rdy;
    assign w_push_ok = (count != C_FULL) || w_pop;

    always_comb begin
        sync_d[0] = in;
        for (int s = 1; s < SYNC_STAGES; s++)
            sync_d[s] = sync_q[s-1];
        prev_d  = w_rails;
        state_d = state_q;
        ack_d   = ack_q;
        w_push  = 1'b0;
        err_d   = err_clr ? 1'b0 : err_q;
        if (w_illegal) begin
            err_d = 1'b1;
        end else begin
            case (state_q)
                WAIT_DATA: begin
                    if (w_complete && w_stable && w_push_ok) begin
                        w_push  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = WAIT_SPACER;
                    end
                end
                WAIT_SPACER: begin
                    if (w_spacer) begin
                        ack_d   = 1'b0;
                        state_d = WAIT_DATA;
                    end
                end
                default: state_d = WAIT_DATA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= '0;
            prev_q  <= '0;
            state_q <= WAIT_DATA;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++)
                sync_q[s] <= sync_d[s];
            prev_q  <= prev_d;
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign ack_o = ack_q;
    assign err_o = err_q;

    dr_rx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_decoded[WIDTH-1:0]),
        .pop       (w_pop),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .count     (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_dr_link_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dr_link_rx_fifo
//  Purpose  : Scoreboard bench for the dual-rail receiver FIFO.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dr_link_rx_fifo;

    localparam int W = 8;

    logic           clk      = 1'b0;
    logic           rst_n    = 1'b0;
    logic [2*W-1:0] in_rails = '0;
    logic           ack_o;
    logic [W-1:0]   dout;
    logic           dout_vld;
    logic           dout_rdy = 1'b0;
    logic [2:0]     count;
    logic           err_o;
    logic           err_clr  = 1'b0;

    int           checks    = 0;
    int           errors    = 0;
    int           ack_rises = 0;
    bit           done      = 1'b0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    dr_link_rx_fifo #(
        .WIDTH       (W),
        .DEPTH       (4),
        .SYNC_STAGES (2),
        .INIT        (8'h00)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_rails),
        .ack_o    (ack_o),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .count    (count),
        .err_o    (err_o),
        .err_clr  (err_clr)
    );

    function automatic logic [2*W-1:0] enc(input logic [W-1:0] w);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++)
            r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int k;
        k = 0;
        while (ack_o !== v && k < 200) begin
            tick(1);
            k++;
        end
        chk(name, ack_o, v);
    endtask

    task automatic send(input logic [W-1:0] w);
        exp_q.push_back(w);
        in_rails = enc(w);
        wait_ack(1'b1, "send_ack_high");
        in_rails = '0;
        wait_ack(1'b0, "send_ack_low");
    endtask

    task automatic drain();
        int k;
        k = 0;
        dout_rdy = 1'b1;
        while (count != 0 && k < 100) begin
            tick(1);
            k++;
        end
        dout_rdy = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_scoreboard_empty", exp_q.size(), 0);
    endtask

    // Monitor: every accepted output word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count_le_depth", (count <= 3'd4), 1);
            if (dout_vld && dout_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_unexpected actual=0x%0h required=none", dout);
                end else begin
                    chk("scoreboard_data", dout, exp_q.pop_front());
                end
            end
        end
    end

    always @(posedge ack_o) ack_rises++;

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic [2*W-1:0] r;

        // Reset state
        tick(3);
        chk("reset_ack", ack_o, 0);
        chk("reset_vld", dout_vld, 0);
        chk("reset_dout", dout, 8'h00);
        chk("reset_count", count, 0);
        chk("reset_err", err_o, 0);
        rst_n = 1'b1;

        // Single word latency and spacer return
        exp_q.push_back(8'hA5);
        in_rails = 16'h9966;
        tick(3);
        chk("lat_ack_edge3", ack_o, 0);
        chk("lat_vld_edge3", dout_vld, 0);
        tick(1);
        chk("lat_ack_edge4", ack_o, 1);
        chk("lat_vld_edge4", dout_vld, 1);
        chk("lat_dout_edge4", dout, 8'hA5);
        chk("lat_count_edge4", count, 1);
        in_rails = '0;
        tick(2);
        chk("spacer_ack_edge2", ack_o, 1);
        tick(1);
        chk("spacer_ack_edge3", ack_o, 0);
        dout_rdy = 1'b1;
        tick(1);
        dout_rdy = 1'b0;
        chk("pop_count", count, 0);
        chk("pop_dout_init", dout, 8'h00);
        chk("pop_vld", dout_vld, 0);

        // Backpressure with full FIFO
        for (int i = 1; i <= 4; i++) send(8'(i));
        chk("full_count", count, 4);
        exp_q.push_back(8'h05);
        in_rails = enc(8'h05);
        tick(10);
        chk("full_hold_ack", ack_o, 0);
        chk("full_hold_count", count, 4);
        dout_rdy = 1'b1;
        tick(1);
        dout_rdy = 1'b0;
        chk("full_popush_ack", ack_o, 1);
        chk("full_popush_count", count, 4);
        in_rails = '0;
        wait_ack(1'b0, "full_spacer_ack");
        drain();

        // Illegal codeword and sticky error
        in_rails = 16'h55EA;
        tick(6);
        chk("illegal_err", err_o, 1);
        chk("illegal_ack", ack_o, 0);
        chk("illegal_count", count, 0);
        in_rails = '0;
        tick(4);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clear", err_o, 0);
        in_rails = 16'h55EA;
        err_clr  = 1'b1;
        tick(6);
        chk("err_set_wins", err_o, 1);
        err_clr  = 1'b0;
        in_rails = '0;
        tick(4);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clear2", err_o, 0);
        chk("illegal_no_push", count, 0);

        // Skewed arrival, one rail pair per cycle
        base = ack_rises;
        exp_q.push_back(8'h5A);
        r = enc(8'h5A);
        for (int i = 0; i < W; i++) begin
            in_rails[2*i +: 2] = r[2*i +: 2];
            tick(1);
            if (i < W-1) chk("skew_no_push", count, 0);
        end
        wait_ack(1'b1, "skew_ack_high");
        chk("skew_dout", dout, 8'h5A);
        in_rails = '0;
        wait_ack(1'b0, "skew_ack_low");
        chk("skew_count", count, 1);
        chk("skew_one_ack", ack_rises - base, 1);
        drain();

        // Back-to-back traffic with random consumer stalls
        fork
            begin
                for (int i = 0; i < 16; i++) send(8'($urandom_range(0, 255)));
                done = 1'b1;
            end
            begin
                while (!done) begin
                    dout_rdy = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        drain();

        // Asynchronous reset mid-handshake
        send(8'h3C);
        in_rails = enc(8'hC3);
        exp_q.push_back(8'hC3);
        wait_ack(1'b1, "midrst_ack_high");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", ack_o, 0);
        chk("midrst_count", count, 0);
        chk("midrst_vld", dout_vld, 0);
        exp_q.delete();
        in_rails = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        send(8'h81);
        chk("recover_dout", dout, 8'h81);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
